uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester 8N1 UART transmitter; ties alternate, starting with requester 0.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [13:0] LAST_CNT = 14'(CLKS_PER_BIT - 1);
    state_t      state_q;
    logic [13:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  sh_q;
    logic        tx_q, busy_q, done_q, grant_q, last_q;
    logic        bit_end, open, winner;
    assign bit_end = cnt_q == LAST_CNT;
    assign open    = reset && state_q == IDLE && enable;
    // A tie goes to whoever did not own the previous frame.
    assign winner     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = open && req0_valid && !winner;
    assign req1_ready = open && req1_valid && winner;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign grant = grant_q;
    assign done  = done_q;
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= bit_end ? '0 : cnt_q + 14'd1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req0_ready || req1_ready) begin
                        state_q <= START;
                        sh_q    <= winner ? req1_data : req0_data;
                        grant_q <= winner;
                        last_q  <= winner;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    idx_q   <= '0;
                    tx_q    <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                end
                DATA: if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        tx_q  <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                    end
                end
                STOP: if (bit_end) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
